tagged_memory: RTL and testbench

// - 1M-word x 64-bit main memory; each word carries an 8-bit tag (72 bits stored).
// - Slave on the CPU's multiplexed address/data bus: address strobe, then read/write cycles.
// - Sits beside the microprogrammed CPU in simulation and the FPGA top.
// - Exposes the latched word address `waddr` so the trace monitor can log physical addresses.
//

---
 rtl/tagged_memory.sv | 79 +++++++
 tb/tb_tagged_memory.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/tagged_memory.sv
// tagged_memory: word-addressed main memory where each DW-bit word carries a
// TW-bit tag. It is a slave on the CPU's multiplexed address/data bus. An
// address strobe latches the word address, and read/write cycles that follow
// use that latched address until the next strobe.
module tagged_memory #(
    parameter int AW = 20,
    parameter int DW = 64,
    parameter int TW = 8
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [DW-1:0] o_ad,
    input  logic [TW-1:0] o_tag,
    input  logic          o_astb,
    input  logic          o_atomic,
    input  logic          o_rd,
    input  logic          o_wr,
    output logic [DW-1:0] i_data,
    output logic [TW-1:0] i_tag,
    output logic [AW-1:0] waddr
);

    localparam int DEPTH = 2 ** AW;
    localparam int SW    = TW + DW;   // stored word: {tag, data}

    // Tag and data share one array entry so that a single access moves both.
    // The array is not cleared by reset.
    logic [SW-1:0] mem [0:DEPTH-1];

    // Latched read-modify-write flag. It has no port. It records that the
    // current address belongs to a locked rd/wr pair.
    logic          atomic_reg;

    // A read in the strobe cycle uses the address on the bus. Any other read
    // uses the address latched earlier. Upper bus bits are dropped, so the
    // address wraps modulo the depth.
    logic [AW-1:0] eaddr;
    logic          wr_en;
    logic          rd_en;

    // A write in a strobe cycle is ignored, because the bus carries an address
    // and not data. A cycle with reset asserted drops any rd/wr.
    assign eaddr = o_astb ? o_ad[AW-1:0] : waddr;
    assign wr_en = o_wr && !o_astb && !reset;
    assign rd_en = o_rd && !reset;

    // Array write port: {tag, data} goes to the latched address.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[waddr] <= {o_tag, o_ad};
        end
    end

    // Registered read port. The read is read-first, so a read in the same
    // cycle as a write returns the old contents. The result holds until the
    // next read or until reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            {i_tag, i_data} <= '0;
        end else if (rd_en) begin
            {i_tag, i_data} <= mem[eaddr];
        end
    end

    // Address latch and atomic flag. A strobe reloads both. The first write
    // of a locked sequence releases the flag.
    always_ff @(posedge clk) begin
        if (reset) begin
            waddr      <= '0;
            atomic_reg <= 1'b0;
        end else if (o_astb) begin
            waddr      <= o_ad[AW-1:0];
            atomic_reg <= o_atomic;
        end else if (o_wr && atomic_reg) begin
            atomic_reg <= 1'b0;
        end
    end

endmodule

// File: tb/tb_tagged_memory.sv
// tb_tagged_memory: directed vectors for tagged_memory. Each read pushes the
// expected {tag, data} into a queue. A monitor pops the queue and compares
// whenever the DUT presents read data, which is one cycle after an accepted
// read.
module tb_tagged_memory;

    localparam int AW = 20;
    localparam int DW = 64;
    localparam int TW = 8;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic [DW-1:0] o_ad = '0;
    logic [TW-1:0] o_tag = '0;
    logic          o_astb = 1'b0;
    logic          o_atomic = 1'b0;
    logic          o_rd = 1'b0;
    logic          o_wr = 1'b0;
    logic [DW-1:0] i_data;
    logic [TW-1:0] i_tag;
    logic [AW-1:0] waddr;

    int vectors = 0;
    int miscompares = 0;

    logic [TW+DW-1:0] exp_q [$];
    string            name_q [$];
    logic             rd_seen = 1'b0;

    tagged_memory #(.AW(AW), .DW(DW), .TW(TW)) dut (
        .clk      (clk),
        .reset    (reset),
        .o_ad     (o_ad),
        .o_tag    (o_tag),
        .o_astb   (o_astb),
        .o_atomic (o_atomic),
        .o_rd     (o_rd),
        .o_wr     (o_wr),
        .i_data   (i_data),
        .i_tag    (i_tag),
        .waddr    (waddr)
    );

    always #5 clk = ~clk;

    // Valid marker: a read accepted at this edge gives data after the edge.
    always @(posedge clk) rd_seen <= o_rd && !reset;

    // Monitor: compare the presented read data against the oldest expectation.
    always @(negedge clk) begin
        if (rd_seen) begin
            vectors++;
            if (exp_q.size() == 0) begin
                miscompares++;
                $display("FAIL rd_unexpected: got tag=%h data=%h, required no read", i_tag, i_data);
            end else begin
                logic [TW+DW-1:0] e;
                string            n;
                e = exp_q.pop_front();
                n = name_q.pop_front();
                if ({i_tag, i_data} !== e) begin
                    miscompares++;
                    $display("FAIL %s: got tag=%h data=%h, required tag=%h data=%h",
                             n, i_tag, i_data, e[TW+DW-1:DW], e[DW-1:0]);
                end else begin
                    $display("read  %-14s tag=%h data=%h ok", n, i_tag, i_data);
                end
            end
        end
    end

    // Drives one bus cycle. A read pushes its expectation first.
    task automatic bus(input logic astb, input logic atomic, input logic rd,
                       input logic wr, input logic [DW-1:0] ad,
                       input logic [TW-1:0] tag, input logic [TW+DW-1:0] exp_rd,
                       input string name);
        o_astb   = astb;
        o_atomic = atomic;
        o_rd     = rd;
        o_wr     = wr;
        o_ad     = ad;
        o_tag    = tag;
        if (rd && !reset) begin
            exp_q.push_back(exp_rd);
            name_q.push_back(name);
        end
        $display("cycle %-14s astb=%b at=%b rd=%b wr=%b rst=%b ad=%h tag=%h",
                 name, astb, atomic, rd, wr, reset, ad, tag);
        @(posedge clk);
        #1;
        o_astb = 1'b0; o_atomic = 1'b0; o_rd = 1'b0; o_wr = 1'b0;
    endtask

    // Direct comparison of an output that is not read data.
    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s: got %h, required %h", name, act, req);
        end else begin
            $display("check %-14s %h ok", name, act);
        end
    endtask

    initial begin
        @(posedge clk);
        #1;
        // Reset for one clock.
        reset = 1'b1;
        bus(0, 0, 0, 0, '0, '0, '0, "reset");
        reset = 1'b0;
        chk("rst_waddr", 128'(waddr), 128'h0);
        chk("rst_data",  128'(i_data), 128'h0);
        chk("rst_tag",   128'(i_tag), 128'h0);
        bus(0, 0, 1, 0, '0, '0, 72'h00_00000000_00000000, "rd_word0");

        // Write, then read back, at 0x12345.
        bus(1, 0, 0, 0, 64'h12345, '0, '0, "astb_12345");
        bus(0, 0, 0, 1, 64'hDEADBEEF_01234567, 8'h35, '0, "wr_12345");
        bus(0, 0, 1, 0, '0, '0, 72'h35_DEADBEEF_01234567, "rd_12345");
        chk("waddr_12345", 128'(waddr), 128'h12345);

        // Upper address bits are dropped. Then a read shares a strobe cycle.
        bus(1, 0, 0, 0, 64'h0000_0000_0100_0007, '0, '0, "astb_wrap7");
        chk("waddr_wrap7", 128'(waddr), 128'h7);
        bus(0, 0, 0, 1, 64'h77, 8'h07, '0, "wr_7");
        bus(1, 0, 0, 0, 64'h0, '0, '0, "astb_0");
        bus(1, 0, 1, 0, 64'h7, '0, 72'h07_00000000_00000077, "astb_rd_7");

        // Read and write in the same cycle: the read returns the old word.
        bus(1, 0, 0, 0, 64'h5, '0, '0, "astb_5");
        bus(0, 0, 0, 1, 64'h11, 8'h01, '0, "wr_5_old");
        bus(0, 0, 1, 1, 64'h22, 8'h02, 72'h01_00000000_00000011, "rdwr_5");
        bus(0, 0, 1, 0, '0, '0, 72'h02_00000000_00000022, "rd_5_new");

        // Atomic read-modify-write at 9.
        bus(1, 1, 0, 0, 64'h9, '0, '0, "astb_at_9");
        bus(0, 0, 1, 0, '0, '0, 72'h00_00000000_00000000, "rd_at_9");
        bus(0, 0, 0, 1, 64'hAA, 8'h0A, '0, "wr_at_9");
        bus(0, 0, 1, 0, '0, '0, 72'h0A_00000000_000000AA, "rd2_at_9");
        chk("waddr_9", 128'(waddr), 128'h9);

        // A write in a strobe cycle is ignored.
        bus(1, 0, 0, 1, 64'h40000, 8'h5A, '0, "astbwr_40000");
        chk("waddr_40000", 128'(waddr), 128'h40000);
        bus(0, 0, 1, 0, '0, '0, 72'h00_00000000_00000000, "rd_40000");
        bus(1, 0, 0, 1, 64'h100000, 8'h5A, '0, "astbwr_wrap0");
        chk("waddr_wrap0", 128'(waddr), 128'h0);
        bus(0, 0, 1, 0, '0, '0, 72'h00_00000000_00000000, "rd_0_clean");

        // Idle cycles hold the read data.
        bus(1, 0, 1, 0, 64'h7, '0, 72'h07_00000000_00000077, "rd_7_again");
        bus(0, 0, 0, 0, '0, '0, '0, "idle1");
        bus(0, 0, 0, 0, '0, '0, '0, "idle2");
        chk("idle_hold", 128'({i_tag, i_data}), 128'h07_00000000_00000077);
        chk("idle_waddr", 128'(waddr), 128'h7);

        // Reset in the middle of a sequence drops the rd/wr and clears waddr.
        reset = 1'b1;
        bus(0, 0, 1, 1, 64'h99, 8'h09, '0, "rst_mid");
        reset = 1'b0;
        chk("mid_waddr", 128'(waddr), 128'h0);
        chk("mid_rdata", 128'({i_tag, i_data}), 128'h0);
        bus(1, 0, 1, 0, 64'h7, '0, 72'h07_00000000_00000077, "rd_7_postrst");

        // Drain, then confirm every expectation was consumed.
        repeat (3) @(posedge clk);
        #1;
        chk("queue_empty", 128'(exp_q.size()), 128'h0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
